// File: rtl/l2_port_arbiter.sv
// Shares the single L1-side L2 port between the I-cache (read-only) and the D-cache.
// The grant is held until L2 completes, requesters alternate on conflict, and the statistics counters saturate.
module l2_port_arbiter #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               I_read,
    input  logic [27:0]        I_addr,
    output logic [127:0]       I_rdata,
    output logic               I_ready,
    input  logic               D_read,
    input  logic               D_write,
    input  logic [27:0]        D_addr,
    input  logic [127:0]       D_wdata,
    output logic [127:0]       D_rdata,
    output logic               D_ready,
    output logic               L2_read,
    output logic               L2_write,
    output logic [27:0]        L2_addr,
    output logic [127:0]       L2_wdata,
    input  logic [127:0]       L2_rdata,
    input  logic               L2_ready,
    output logic [CNT_W-1:0]   I_grants,
    output logic [CNT_W-1:0]   D_grants,
    output logic [CNT_W-1:0]   conflict_cycles
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t state_reg, state_next;
    logic   last_d_reg, last_d_next;    // 1 = D was served last
    logic   req_i, req_d;

    assign req_i = I_read;
    assign req_d = D_read | D_write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        L2_read     = 1'b0;
        L2_write    = 1'b0;
        L2_addr     = '0;
        L2_wdata    = '0;
        I_ready     = 1'b0;
        I_rdata     = '0;
        D_ready     = 1'b0;
        D_rdata     = '0;
        case (state_reg)
            IDLE: begin
                if (req_i && (!req_d || last_d_reg))
                    state_next = GNT_I;
                else if (req_d)
                    state_next = GNT_D;
            end
            GNT_I: begin
                L2_read = I_read;
                L2_addr = I_addr;
                // A dropped request still waits for L2_ready, then releases silently
                if (L2_ready) begin
                    I_ready     = req_i;
                    I_rdata     = req_i ? L2_rdata : '0;
                    last_d_next = 1'b0;
                    state_next  = req_d ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                L2_read  = D_read;
                L2_write = D_write;
                L2_addr  = D_addr;
                L2_wdata = D_wdata;
                if (L2_ready) begin
                    D_ready     = req_d;
                    D_rdata     = req_d ? L2_rdata : '0;
                    last_d_next = 1'b1;
                    state_next  = req_i ? GNT_I : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter 0: I grants, 1: D grants, 2: conflict cycles
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc[0] = I_ready;
    assign cnt_inc[1] = D_ready;
    assign cnt_inc[2] = ((state_reg == GNT_I) && req_d) || ((state_reg == GNT_D) && req_i);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign I_grants        = cnt_reg[0];
    assign D_grants        = cnt_reg[1];
    assign conflict_cycles = cnt_reg[2];

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a 32-bit-counter instance and a 4-bit-counter instance share all stimulus.
module tb_l2_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         I_read, D_read, D_write, L2_ready;
    logic [27:0]  I_addr, D_addr;
    logic [127:0] D_wdata, L2_rdata;

    logic [127:0] I_rdata, D_rdata, L2_wdata;
    logic         I_ready, D_ready, L2_read, L2_write;
    logic [27:0]  L2_addr;
    logic [31:0]  I_grants, D_grants, conflict_cycles;

    logic [127:0] s_I_rdata, s_D_rdata, s_L2_wdata;
    logic         s_I_ready, s_D_ready, s_L2_read, s_L2_write;
    logic [27:0]  s_L2_addr;
    logic [3:0]   s_I_grants, s_D_grants, s_conflict_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_port_arbiter #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .I_read(I_read), .I_addr(I_addr), .I_rdata(I_rdata), .I_ready(I_ready),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_ready(D_ready),
        .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
        .L2_rdata(L2_rdata), .L2_ready(L2_ready),
        .I_grants(I_grants), .D_grants(D_grants), .conflict_cycles(conflict_cycles)
    );

    l2_port_arbiter #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .I_read(I_read), .I_addr(I_addr), .I_rdata(s_I_rdata), .I_ready(s_I_ready),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(s_D_rdata), .D_ready(s_D_ready),
        .L2_read(s_L2_read), .L2_write(s_L2_write), .L2_addr(s_L2_addr), .L2_wdata(s_L2_wdata),
        .L2_rdata(L2_rdata), .L2_ready(L2_ready),
        .I_grants(s_I_grants), .D_grants(s_D_grants), .conflict_cycles(s_conflict_cycles)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        I_read = 0; D_read = 0; D_write = 0; L2_ready = 0;
        I_addr = '0; D_addr = '0; D_wdata = '0; L2_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        clear_inputs();

        // Reset with both requesters active and L2 ready
        reset = 0; I_read = 1; D_read = 1; L2_ready = 1; L2_rdata = 128'hFF;
        step();
        step();
        #1;
        check("rst_L2_read", L2_read, 0);
        check("rst_L2_write", L2_write, 0);
        check("rst_I_ready", I_ready, 0);
        check("rst_D_ready", D_ready, 0);
        check("rst_D_rdata", D_rdata, 0);
        check("rst_I_grants", I_grants, 0);
        check("rst_conflict", conflict_cycles, 0);
        clear_inputs();
        reset = 1;
        step();
        check("idle_L2_read", L2_read, 0);
        $display("txn reset done");

        // Single I hit
        do_reset();
        I_read = 1; I_addr = 28'h0000123; L2_ready = 1; L2_rdata = 128'hA5;
        #1 check("ihit_c0_L2_read", L2_read, 0);
        step();
        check("ihit_c1_L2_read", L2_read, 1);
        check("ihit_c1_L2_addr", L2_addr, 28'h0000123);
        check("ihit_c1_I_ready", I_ready, 1);
        check("ihit_c1_I_rdata", I_rdata, 128'hA5);
        step();
        I_read = 0;
        #1 check("ihit_I_grants", I_grants, 1);
        $display("txn single I hit");

        // Simultaneous conflict from reset: I wins, D follows without a bubble
        do_reset();
        L2_ready = 1; L2_rdata = 128'h77;
        I_read = 1; I_addr = 28'h0000010;
        D_write = 1; D_addr = 28'h0000020; D_wdata = 128'hDEAD_BEEF;
        step();
        check("conf_c1_I_ready", I_ready, 1);
        check("conf_c1_D_ready", D_ready, 0);
        check("conf_c1_L2_write", L2_write, 0);
        step();
        I_read = 0;
        #1;
        check("conf_c2_L2_write", L2_write, 1);
        check("conf_c2_L2_wdata", L2_wdata, 128'hDEAD_BEEF);
        check("conf_c2_L2_addr", L2_addr, 28'h0000020);
        check("conf_c2_D_ready", D_ready, 1);
        check("conf_c2_I_ready", I_ready, 0);
        step();
        D_write = 0;
        #1;
        check("conf_conflict", conflict_cycles, 1);
        check("conf_D_grants", D_grants, 1);
        $display("txn simultaneous conflict");

        // Round-robin over 6 hits with both requesting continuously
        do_reset();
        L2_ready = 1; I_read = 1; D_read = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rr_c%0d_I_ready", k), I_ready, (k % 2) == 1);
            check($sformatf("rr_c%0d_D_ready", k), D_ready, (k % 2) == 0);
        end
        step();
        I_read = 0; D_read = 0;
        step();
        check("rr_I_grants", I_grants, 3);
        check("rr_D_grants", D_grants, 3);
        check("rr_conflict", conflict_cycles, 6);
        $display("txn round-robin");

        // Long D miss with I waiting from the second grant cycle onward
        do_reset();
        D_read = 1; D_addr = 28'h0000ABC; L2_rdata = 128'h55;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k == 2) I_read = 1;
            if (k == 2) I_addr = 28'h0000DEF;
            L2_ready = (k == 21);
            #1;
            check($sformatf("miss_c%0d_D_ready", k), D_ready, k == 21);
            check($sformatf("miss_c%0d_I_ready", k), I_ready, 0);
        end
        step();
        D_read = 0;
        #1;
        check("miss_c22_L2_addr", L2_addr, 28'h0000DEF);
        check("miss_c22_I_ready", I_ready, 1);
        step();
        I_read = 0;
        #1;
        check("miss_conflict", conflict_cycles, 20);
        check("miss_I_grants", I_grants, 1);
        $display("txn long miss");

        // Saturation on the 4-bit instance: 20 I hits, one per two cycles
        do_reset();
        L2_ready = 1; I_read = 1;
        for (int k = 0; k < 40; k++) step();
        I_read = 0;
        step();
        check("sat_small_I_grants", s_I_grants, 15);
        check("sat_big_I_grants", I_grants, 20);

        // Abort: D_write drops mid-grant, grant held until L2_ready
        D_write = 1; L2_ready = 0;
        step();
        D_write = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("abort_w%0d_D_ready", k), D_ready, 0);
            step();
        end
        L2_ready = 1;
        #1 check("abort_rel_D_ready", D_ready, 0);
        step();
        D_read = 1;
        #1 check("abort_idle_L2_read", L2_read, 0);
        check("abort_D_grants", D_grants, 0);
        check("abort_small_D_grants", s_D_grants, 0);
        step();
        check("abort_next_D_ready", D_ready, 1);
        step();
        D_read = 0;
        $display("txn saturation and abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
